// File: rtl/csi2_pkg.sv
// Shared constants, state encoding and command payload for the CSI-2 packet sequencer.
package csi2_pkg;

  localparam int unsigned DT_W   = 6;
  localparam int unsigned VC_W   = 2;
  localparam int unsigned WC_W   = 16;
  localparam int unsigned LCNT_W = 12;

  localparam logic [DT_W-1:0] DT_FS       = 6'h00;
  localparam logic [DT_W-1:0] DT_FE       = 6'h01;
  localparam logic [DT_W-1:0] DT_YUV422_8 = 6'h1E;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HS_ENTER,
    ST_SEND_FS,
    ST_WAIT_LINE,
    ST_SEND_LH,
    ST_LINE_ACT,
    ST_SEND_FE,
    ST_HS_EXIT
  } state_t;

  typedef struct packed {
    logic [DT_W-1:0] dt;
    logic [VC_W-1:0] vc;
    logic [WC_W-1:0] wc;
  } cmd_t;

endpackage

// File: rtl/edge_det.sv
// Registers a level once and flags rising/falling transitions of the registered copy.
module edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise_c,
  output logic fall_c
);

  logic q;
  logic q_d;

  // Both stages reset high so a level already asserted at reset release is not a new edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q   <= 1'b1;
      q_d <= 1'b1;
    end else begin
      q   <= d;
      q_d <= q;
    end
  end

  assign rise_c = q & ~q_d;
  assign fall_c = ~q & q_d;

endmodule

// File: rtl/csi2_pkt_sequencer.sv
// Turns frame/line envelopes into ordered CSI-2 packet commands and runs the D-PHY HS handshake.
module csi2_pkt_sequencer
  import csi2_pkg::*;
#(
  parameter logic [5:0]  DATA_TYPE  = DT_YUV422_8,
  parameter int unsigned WORD_COUNT = 2560,
  parameter logic [1:0]  VC         = 2'd0,
  parameter int unsigned FNUM_MAX   = 2,
  parameter int unsigned HS_TIMEOUT = 1023
) (
  input  logic        sys_clk,
  input  logic        n_rst,
  input  logic        fv_i,
  input  logic        lv_i,
  output logic        cmd_valid_o,
  input  logic        cmd_ready_i,
  output logic [5:0]  cmd_dt_o,
  output logic [1:0]  cmd_vc_o,
  output logic [15:0] cmd_wc_o,
  output logic        hs_req_o,
  input  logic        hs_ack_i,
  output logic        pix_en_o,
  output logic [11:0] line_cnt_o,
  output logic [1:0]  err_o
);

  localparam int unsigned TO_W = $clog2(HS_TIMEOUT + 1);
  localparam logic [LCNT_W-1:0] LCNT_MAX = '1;

  state_t            state, state_d;
  cmd_t              cmd_q, cmd_d;
  logic              cmd_valid_d, hs_req_d, pix_en_d;
  logic [LCNT_W-1:0] line_cnt_d;
  logic [1:0]        err_d;
  logic [WC_W-1:0]   fnum, fnum_d;
  logic [TO_W-1:0]   to_cnt, to_cnt_d;
  logic              fv_end, fv_end_d;
  logic              fv_rise_c, fv_fall_c, lv_rise_c, lv_fall_c;
  logic              cmd_hs_c;

  edge_det u_fv_edge (
    .clk    (sys_clk),
    .rst_n  (n_rst),
    .d      (fv_i),
    .rise_c (fv_rise_c),
    .fall_c (fv_fall_c)
  );

  edge_det u_lv_edge (
    .clk    (sys_clk),
    .rst_n  (n_rst),
    .d      (lv_i),
    .rise_c (lv_rise_c),
    .fall_c (lv_fall_c)
  );

  assign cmd_hs_c = cmd_valid_o & cmd_ready_i;
  assign cmd_dt_o = cmd_q.dt;
  assign cmd_vc_o = cmd_q.vc;
  assign cmd_wc_o = cmd_q.wc;

  // Next-state and next-output logic
  always_comb begin
    state_d     = state;
    cmd_d       = cmd_q;
    cmd_valid_d = cmd_valid_o;
    hs_req_d    = hs_req_o;
    pix_en_d    = 1'b0;
    line_cnt_d  = line_cnt_o;
    err_d       = err_o;
    fnum_d      = fnum;
    to_cnt_d    = to_cnt;
    fv_end_d    = fv_end | fv_fall_c;

    case (state)
      ST_IDLE: begin
        fv_end_d = 1'b0;
        to_cnt_d = '0;
        if (fv_rise_c) begin
          state_d  = ST_HS_ENTER;
          hs_req_d = 1'b1;
        end
      end
      ST_HS_ENTER: begin
        to_cnt_d = to_cnt + 1'b1;
        if (hs_ack_i) begin
          state_d     = ST_SEND_FS;
          cmd_valid_d = 1'b1;
          cmd_d.dt    = DT_FS;
          cmd_d.vc    = VC;
          cmd_d.wc    = fnum;
        end else if (to_cnt == TO_W'(HS_TIMEOUT)) begin
          state_d  = ST_HS_EXIT;
          hs_req_d = 1'b0;
          err_d[1] = 1'b1;
        end
      end
      ST_SEND_FS: begin
        if (cmd_hs_c) begin
          state_d     = ST_WAIT_LINE;
          cmd_valid_d = 1'b0;
          line_cnt_d  = '0;
          err_d       = '0;
        end
      end
      ST_WAIT_LINE: begin
        if (fv_end_d) begin
          state_d     = ST_SEND_FE;
          cmd_valid_d = 1'b1;
          cmd_d.dt    = DT_FE;
          cmd_d.vc    = VC;
          cmd_d.wc    = fnum;
        end else if (lv_rise_c) begin
          state_d     = ST_SEND_LH;
          cmd_valid_d = 1'b1;
          cmd_d.dt    = DATA_TYPE;
          cmd_d.vc    = VC;
          cmd_d.wc    = WC_W'(WORD_COUNT);
        end
      end
      ST_SEND_LH: begin
        if (cmd_hs_c) begin
          state_d     = lv_fall_c ? ST_WAIT_LINE : ST_LINE_ACT;
          cmd_valid_d = 1'b0;
          pix_en_d    = 1'b1;
          if (line_cnt_o != LCNT_MAX) line_cnt_d = line_cnt_o + 1'b1;
        end else if (lv_fall_c) begin
          // Line ended before its header was accepted: withdraw and flag the drop.
          state_d     = ST_WAIT_LINE;
          cmd_valid_d = 1'b0;
          err_d[0]    = 1'b1;
        end
      end
      ST_LINE_ACT: begin
        if (lv_fall_c) state_d  = ST_WAIT_LINE;
        else           pix_en_d = 1'b1;
      end
      ST_SEND_FE: begin
        if (cmd_hs_c) begin
          state_d     = ST_HS_EXIT;
          cmd_valid_d = 1'b0;
          hs_req_d    = 1'b0;
          fnum_d      = (fnum == WC_W'(FNUM_MAX)) ? WC_W'(1) : fnum + 1'b1;
        end
      end
      ST_HS_EXIT: begin
        if (!hs_ack_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A line starting while no header can be taken is skipped; outside a frame it is ignored.
    if (lv_rise_c && (state inside {ST_HS_ENTER, ST_SEND_FS, ST_LINE_ACT, ST_SEND_FE}))
      err_d[0] = 1'b1;
  end

  always_ff @(posedge sys_clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= ST_IDLE;
      cmd_q       <= '0;
      cmd_valid_o <= 1'b0;
      hs_req_o    <= 1'b0;
      pix_en_o    <= 1'b0;
      line_cnt_o  <= '0;
      err_o       <= '0;
      fnum        <= WC_W'(1);
      to_cnt      <= '0;
      fv_end      <= 1'b0;
    end else begin
      state       <= state_d;
      cmd_q       <= cmd_d;
      cmd_valid_o <= cmd_valid_d;
      hs_req_o    <= hs_req_d;
      pix_en_o    <= pix_en_d;
      line_cnt_o  <= line_cnt_d;
      err_o       <= err_d;
      fnum        <= fnum_d;
      to_cnt      <= to_cnt_d;
      fv_end      <= fv_end_d;
    end
  end

endmodule

// File: tb/tb_csi2_pkt_sequencer.sv
// Self-checking bench: directed frame scenarios with randomized timing against a command-list model.
module tb_csi2_pkt_sequencer;

  logic        sys_clk;
  logic        n_rst;
  logic        fv_i;
  logic        lv_i;
  logic        cmd_valid_o;
  logic        cmd_ready_i;
  logic [5:0]  cmd_dt_o;
  logic [1:0]  cmd_vc_o;
  logic [15:0] cmd_wc_o;
  logic        hs_req_o;
  logic        hs_ack_i;
  logic        pix_en_o;
  logic [11:0] line_cnt_o;
  logic [1:0]  err_o;

  int vectors;
  int miscompares;
  int withdraws;
  int rdy_mode;
  int lows;
  int fnum_m;
  int nl;
  int n;
  logic [23:0] got[$];
  logic [23:0] exp_q[$];

  csi2_pkt_sequencer dut (
    .sys_clk     (sys_clk),
    .n_rst       (n_rst),
    .fv_i        (fv_i),
    .lv_i        (lv_i),
    .cmd_valid_o (cmd_valid_o),
    .cmd_ready_i (cmd_ready_i),
    .cmd_dt_o    (cmd_dt_o),
    .cmd_vc_o    (cmd_vc_o),
    .cmd_wc_o    (cmd_wc_o),
    .hs_req_o    (hs_req_o),
    .hs_ack_i    (hs_ack_i),
    .pix_en_o    (pix_en_o),
    .line_cnt_o  (line_cnt_o),
    .err_o       (err_o)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  function automatic logic [23:0] mk(input logic [5:0] dt, input logic [15:0] wc);
    return {dt, 2'b00, wc};
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic wait_hs(input logic want, input string tag);
    int k;
    k = 0;
    while (hs_req_o !== want && k < 50) begin
      tick();
      k++;
    end
    check(tag, 32'(hs_req_o), 32'(want));
  endtask

  task automatic wait_cmds(input string tag);
    int k;
    k = 0;
    while (got.size() < exp_q.size() && k < 100) begin
      tick();
      k++;
    end
    check(tag, 32'(got.size()), 32'(exp_q.size()));
  endtask

  task automatic cmp_cmds(input string tag);
    check({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
    foreach (exp_q[i])
      if (i < got.size()) check($sformatf("%s_cmd%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
    got.delete();
    exp_q.delete();
  endtask

  task automatic start_frame(input int ack_dly, input string tag);
    fv_i = 1'b1;
    wait_hs(1'b1, {tag, "_hs_req"});
    repeat (ack_dly) tick();
    hs_ack_i = 1'b1;
    exp_q.push_back(mk(6'h00, 16'(fnum_m)));
    wait_cmds({tag, "_fs"});
    check({tag, "_err_clr"}, 32'(err_o), 32'd0);
  endtask

  task automatic do_line(input int len);
    repeat ($urandom_range(3, 6)) tick();
    lv_i = 1'b1;
    exp_q.push_back(mk(6'h1E, 16'd2560));
    repeat (len) tick();
    lv_i = 1'b0;
  endtask

  task automatic end_frame(input int nlines, input string tag);
    if (fv_i) begin
      repeat (4) tick();
      fv_i = 1'b0;
    end
    exp_q.push_back(mk(6'h01, 16'(fnum_m)));
    wait_cmds({tag, "_fe"});
    wait_hs(1'b0, {tag, "_hs_drop"});
    check({tag, "_lines"}, 32'(line_cnt_o), 32'(nlines));
    repeat (2) tick();
    hs_ack_i = 1'b0;
    repeat (3) tick();
    cmp_cmds(tag);
    fnum_m = fnum_m % 2 + 1;
  endtask

  // Packetiser model: ready is tied, held low, or random with at most three idle cycles in a row.
  initial begin
    lows = 0;
    cmd_ready_i = 1'b1;
    forever begin
      @(posedge sys_clk);
      #1;
      if (rdy_mode == 0)      cmd_ready_i = 1'b0;
      else if (rdy_mode == 1) cmd_ready_i = 1'b1;
      else if (lows >= 3)     cmd_ready_i = 1'b1;
      else                    cmd_ready_i = ($urandom_range(0, 1) == 1);
      lows = cmd_ready_i ? 0 : lows + 1;
    end
  end

  // Command capture plus hold-while-valid check.
  initial begin : monitor
    logic pv, phs;
    logic [23:0] pcmd, cur;
    pv = 1'b0;
    phs = 1'b0;
    pcmd = '0;
    forever begin
      @(negedge sys_clk);
      cur = {cmd_dt_o, cmd_vc_o, cmd_wc_o};
      if (!n_rst) begin
        pv = 1'b0;
        phs = 1'b0;
      end else begin
        if (pv && !phs) begin
          if (!cmd_valid_o) withdraws++;
          else check("cmd_stable", 32'(cur), 32'(pcmd));
        end
        pv = cmd_valid_o;
        phs = cmd_valid_o && cmd_ready_i;
        pcmd = cur;
        if (phs) got.push_back(cur);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vectors = 0;
    miscompares = 0;
    withdraws = 0;
    fnum_m = 1;
    rdy_mode = 1;
    n_rst = 1'b1;
    fv_i = 1'b0;
    lv_i = 1'b0;
    hs_ack_i = 1'b0;
    #2 n_rst = 1'b0;
    #1;
    check("rst_cmd", 32'({cmd_valid_o, cmd_dt_o, cmd_vc_o, cmd_wc_o}), 32'd0);
    check("rst_ctl", 32'({hs_req_o, pix_en_o, line_cnt_o, err_o}), 32'd0);
    repeat (3) tick();
    n_rst = 1'b1;
    repeat (3) tick();

    // Basic frame, ready tied high, three lines
    start_frame(5, "t1");
    for (int i = 0; i < 3; i++) do_line(20);
    end_frame(3, "t1");

    // Back-to-back frames with random timing
    rdy_mode = 2;
    for (int f = 0; f < 4; f++) begin
      start_frame($urandom_range(1, 8), $sformatf("t2f%0d", f));
      nl = $urandom_range(1, 4);
      for (int i = 0; i < nl; i++) do_line($urandom_range(12, 30));
      end_frame(nl, $sformatf("t2f%0d", f));
    end

    // Short line while the packetiser stalls
    start_frame($urandom_range(1, 8), "t3");
    do_line(16);
    repeat (4) tick();
    rdy_mode = 0;
    repeat (2) tick();
    lv_i = 1'b1;
    repeat (4) tick();
    lv_i = 1'b0;
    repeat (4) tick();
    check("t3_err_drop", 32'(err_o), 32'd1);
    check("t3_cnt_held", 32'(line_cnt_o), 32'd1);
    check("t3_withdraw", 32'(withdraws), 32'd1);
    rdy_mode = 2;
    do_line(16);
    end_frame(2, "t3");
    check("t3_err_sticky", 32'(err_o), 32'd1);

    // HS entry never acknowledged
    fv_i = 1'b1;
    wait_hs(1'b1, "t4_hs_req");
    n = 0;
    while (err_o[1] !== 1'b1 && n < 1200) begin
      tick();
      n++;
    end
    check("t4_timeout_cycles", 32'(n), 32'd1024);
    check("t4_err", 32'(err_o), 32'd3);
    check("t4_hs_req_low", 32'(hs_req_o), 32'd0);
    repeat (5) tick();
    fv_i = 1'b0;
    repeat (3) tick();
    check("t4_no_cmds", 32'(got.size()), 32'd0);

    // Frame ends while a line is still active
    start_frame($urandom_range(1, 8), "t5");
    do_line(14);
    repeat (4) tick();
    lv_i = 1'b1;
    exp_q.push_back(mk(6'h1E, 16'd2560));
    repeat (10) tick();
    fv_i = 1'b0;
    repeat (3) tick();
    lv_i = 1'b0;
    tick();
    check("t5_pix_hold", 32'(pix_en_o), 32'd1);
    tick();
    check("t5_pix_drop", 32'(pix_en_o), 32'd0);
    end_frame(2, "t5");

    // Reset in the middle of a line
    start_frame($urandom_range(1, 8), "t6");
    do_line(14);
    repeat (4) tick();
    lv_i = 1'b1;
    exp_q.push_back(mk(6'h1E, 16'd2560));
    repeat (10) tick();
    check("t6_pix_before", 32'(pix_en_o), 32'd1);
    n_rst = 1'b0;
    #1;
    check("t6_rst_cmd", 32'({cmd_valid_o, cmd_dt_o, cmd_vc_o, cmd_wc_o}), 32'd0);
    check("t6_rst_ctl", 32'({hs_req_o, pix_en_o, line_cnt_o, err_o}), 32'd0);
    hs_ack_i = 1'b0;
    repeat (3) tick();
    n_rst = 1'b1;
    fnum_m = 1;
    cmp_cmds("t6_pre");
    repeat (10) tick();
    lv_i = 1'b0;
    repeat (5) tick();
    lv_i = 1'b1;
    repeat (10) tick();
    lv_i = 1'b0;
    repeat (5) tick();
    check("t6_no_hs", 32'(hs_req_o), 32'd0);
    check("t6_no_cmds", 32'(got.size()), 32'd0);
    fv_i = 1'b0;
    repeat (3) tick();
    start_frame($urandom_range(1, 8), "t6b");
    for (int i = 0; i < 2; i++) do_line($urandom_range(12, 30));
    end_frame(2, "t6b");
    check("withdraw_total", 32'(withdraws), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
